// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: per-cycle op encoding and default digit moduli.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INC,
        OP_DEC,
        OP_LOAD,
        OP_CLEAR
    } op_e;

    localparam int SEC_UNITS_MOD = 10;
    localparam int SEC_TENS_MOD  = 6;
    localparam int MIN_UNITS_MOD = 10;

endpackage

// File: rtl/modn_updown_counter_if.sv
// Control and status bundle of one modulo-N digit.
interface modn_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             inc;
    logic             dec;
    logic [WIDTH-1:0] count;
    logic             carry;
    logic             borrow;
    logic             at_max;
    logic             at_zero;
    logic             overflow;

    modport master (
        output clear, load, load_val, inc, dec,
        input  count, carry, borrow, at_max, at_zero, overflow
    );

    modport slave (
        input  clear, load, load_val, inc, dec,
        output count, carry, borrow, at_max, at_zero, overflow
    );
endinterface

// File: rtl/modn_reg.sv
// WIDTH-bit register with synchronous active-high reset.
module modn_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset) q <= '0;
        else       q <= d;
    end

endmodule

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down digit with load, clear, wrap/saturate and cascade outputs.
module modn_updown_counter
    import stopwatch_pkg::*;
#(
    parameter int MODULUS = SEC_TENS_MOD,
    parameter int WIDTH   = 4,
    parameter int WRAP    = 1
) (
    input  logic clock,
    input  logic reset,
    modn_updown_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MODV = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] nxt;
    logic             overflow;
    logic             ovf_nxt;
    logic             carry;
    logic             borrow;
    logic             at_max;
    logic             at_zero;
    logic             clr;
    logic             ld;
    logic             up;
    logic             dn;
    op_e              op;

    assign at_max  = (count == MAXV);
    assign at_zero = (count == '0);

    // Mutually exclusive terms so the decode below carries the priority.
    assign clr = reset | bus.clear;
    assign ld  = ~clr & bus.load;
    assign up  = ~clr & ~bus.load & bus.inc & ~bus.dec;
    assign dn  = ~clr & ~bus.load & bus.dec & ~bus.inc;

    always_comb begin
        op = OP_HOLD;
        unique case (1'b1)
            clr:     op = OP_CLEAR;
            ld:      op = OP_LOAD;
            up:      op = OP_INC;
            dn:      op = OP_DEC;
            default: op = OP_HOLD;
        endcase
    end

    always_comb begin
        nxt     = count;
        ovf_nxt = overflow;
        carry   = 1'b0;
        borrow  = 1'b0;
        unique case (op)
            OP_CLEAR: begin
                nxt     = '0;
                ovf_nxt = 1'b0;
            end
            OP_LOAD: begin
                if ({1'b0, bus.load_val} < MODV) nxt = bus.load_val;
                else                             nxt = MAXV;
            end
            OP_INC: begin
                if (at_max) begin
                    ovf_nxt = 1'b1;
                    if (WRAP != 0) begin
                        nxt   = '0;
                        carry = 1'b1;
                    end
                end else begin
                    nxt = count + WIDTH'(1);
                end
            end
            OP_DEC: begin
                if (at_zero) begin
                    ovf_nxt = 1'b1;
                    if (WRAP != 0) begin
                        nxt    = MAXV;
                        borrow = 1'b1;
                    end
                end else begin
                    nxt = count - WIDTH'(1);
                end
            end
            default: begin
                nxt     = count;
                ovf_nxt = overflow;
            end
        endcase
    end

    modn_reg #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clock (clock),
        .reset (reset),
        .d     (nxt),
        .q     (count)
    );

    always_ff @(posedge clock) begin
        if (reset) overflow <= 1'b0;
        else       overflow <= ovf_nxt;
    end

    assign bus.count    = count;
    assign bus.carry    = carry;
    assign bus.borrow   = borrow;
    assign bus.at_max   = at_max;
    assign bus.at_zero  = at_zero;
    assign bus.overflow = overflow;

endmodule

// File: tb/tb_modn_updown_counter.sv
// Bench for modn_updown_counter: vector table, corner sequences, cascade, random vs model.
module tb_modn_updown_counter;

    logic clock;
    logic reset;
    int   nvec;
    int   nerr;

    modn_updown_counter_if #(.WIDTH(4)) u6_if ();
    modn_updown_counter_if #(.WIDTH(4)) s10_if ();
    modn_updown_counter_if #(.WIDTH(4)) un_if ();
    modn_updown_counter_if #(.WIDTH(4)) te_if ();

    modn_updown_counter #(.MODULUS(6), .WIDTH(4), .WRAP(1)) dut_u6 (
        .clock (clock), .reset (reset), .bus (u6_if)
    );
    modn_updown_counter #(.MODULUS(10), .WIDTH(4), .WRAP(0)) dut_s10 (
        .clock (clock), .reset (reset), .bus (s10_if)
    );
    modn_updown_counter #(.MODULUS(10), .WIDTH(4), .WRAP(1)) dut_un (
        .clock (clock), .reset (reset), .bus (un_if)
    );
    modn_updown_counter #(.MODULUS(6), .WIDTH(4), .WRAP(1)) dut_te (
        .clock (clock), .reset (reset), .bus (te_if)
    );

    // Tens digit counts on the units digit's carry.
    assign te_if.inc = un_if.carry;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit       rst, clr, ld;
        bit [3:0] lv;
        bit       inc, dec;
        bit [3:0] cnt;
        bit       cy, bw, ov;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(bit rst, bit clr, bit ld, int lv, bit inc,
                               bit dec, int cnt, bit cy, bit bw, bit ov);
        vec_t r;
        r.rst = rst; r.clr = clr; r.ld = ld; r.lv = 4'(lv);
        r.inc = inc; r.dec = dec; r.cnt = 4'(cnt);
        r.cy = cy; r.bw = bw; r.ov = ov;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Spec-level digit model: next value by modular or clamped arithmetic.
    task automatic model(input int m, input bit wrap, input bit rst,
                         input bit clr, input bit ld, input int lv,
                         input bit inc, input bit dec, inout int c,
                         inout bit ov, output bit cy, output bit bw);
        cy = 0;
        bw = 0;
        if (rst || clr) begin
            c  = 0;
            ov = 0;
        end else if (ld) begin
            c = (lv < m) ? lv : m - 1;
        end else if (inc && !dec) begin
            if (c == m - 1) begin
                ov = 1;
                cy = wrap;
            end
            c = wrap ? (c + 1) % m : ((c + 1 < m) ? c + 1 : m - 1);
        end else if (dec && !inc) begin
            if (c == 0) begin
                ov = 1;
                bw = wrap;
            end
            c = wrap ? (c + m - 1) % m : ((c > 0) ? c - 1 : 0);
        end
    endtask

    task automatic idle_all();
        u6_if.clear = 0;  u6_if.load = 0;  u6_if.load_val = '0;
        u6_if.inc = 0;    u6_if.dec = 0;
        s10_if.clear = 0; s10_if.load = 0; s10_if.load_val = '0;
        s10_if.inc = 0;   s10_if.dec = 0;
        un_if.clear = 0;  un_if.load = 0;  un_if.load_val = '0;
        un_if.inc = 0;    un_if.dec = 0;
        te_if.clear = 0;  te_if.load = 0;  te_if.load_val = '0;
        te_if.dec = 0;
    endtask

    int  mc[2];
    bit  mo[2];
    int  mm[2];
    bit  mw[2];

    initial begin
        nvec  = 0;
        nerr  = 0;
        reset = 1;
        idle_all();
        tick();
        reset = 0;

        // Reset state
        @(negedge clock);
        chk("rst_count", u6_if.count, 0);
        chk("rst_ovf", u6_if.overflow, 0);
        chk("rst_at_zero", u6_if.at_zero, 1);
        chk("rst_at_max", u6_if.at_max, 0);
        chk("rst_carry", u6_if.carry, 0);
        chk("rst_borrow", u6_if.borrow, 0);
        chk("rst_s10_count", s10_if.count, 0);
        tick();

        // MODULUS=6 WRAP=1 table: expectations are pre-edge state and live outputs
        for (int i = 0; i < 13; i++)
            tbl.push_back(v(0, 0, 0, 0, 1, 0, i % 6, (i % 6) == 5, 0, i >= 6));
        tbl.push_back(v(1, 0, 0, 0, 1, 0, 1, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        for (int k = 5; k >= 1; k--)
            tbl.push_back(v(0, 0, 0, 0, 0, 1, k, 0, 0, 1));
        tbl.push_back(v(0, 0, 1, 7, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 1, 3, 1, 0, 5, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 3, 0, 0, 1));
        tbl.push_back(v(0, 0, 1, 5, 0, 0, 3, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 1, 1, 5, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 5, 0, 0, 1));
        tbl.push_back(v(1, 0, 0, 0, 1, 0, 5, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 5, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 1, 5, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 1, 0, 5, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            reset          = tbl[i].rst;
            u6_if.clear    = tbl[i].clr;
            u6_if.load     = tbl[i].ld;
            u6_if.load_val = tbl[i].lv;
            u6_if.inc      = tbl[i].inc;
            u6_if.dec      = tbl[i].dec;
            @(negedge clock);
            chk($sformatf("t%0d_count", i), u6_if.count, tbl[i].cnt);
            chk($sformatf("t%0d_carry", i), u6_if.carry, tbl[i].cy);
            chk($sformatf("t%0d_borrow", i), u6_if.borrow, tbl[i].bw);
            chk($sformatf("t%0d_ovf", i), u6_if.overflow, tbl[i].ov);
            chk($sformatf("t%0d_at_max", i), u6_if.at_max, tbl[i].cnt == 5);
            chk($sformatf("t%0d_at_zero", i), u6_if.at_zero, tbl[i].cnt == 0);
            tick();
        end
        reset = 0;
        idle_all();

        // MODULUS=10 WRAP=0 saturation, clear, and saturating dec
        s10_if.load = 1; s10_if.load_val = 4'd9;
        tick();
        s10_if.load = 0; s10_if.inc = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("sat_count", s10_if.count, 9);
            chk("sat_carry", s10_if.carry, 0);
            chk("sat_ovf", s10_if.overflow, k > 0);
            tick();
        end
        s10_if.inc = 0; s10_if.clear = 1;
        @(negedge clock);
        chk("sat_pre_clr_ovf", s10_if.overflow, 1);
        tick();
        s10_if.clear = 0; s10_if.dec = 1;
        @(negedge clock);
        chk("sat_clr_count", s10_if.count, 0);
        chk("sat_clr_ovf", s10_if.overflow, 0);
        chk("sat_dec0_borrow", s10_if.borrow, 0);
        tick();
        s10_if.dec = 0;
        @(negedge clock);
        chk("sat_dec0_count", s10_if.count, 0);
        chk("sat_dec0_ovf", s10_if.overflow, 1);
        tick();

        // Two-digit cascade: units mod 10 feeding tens mod 6
        reset = 1;
        un_if.inc = 1;
        tick();
        reset = 0;
        for (int k = 0; k <= 60; k++) begin
            @(negedge clock);
            chk($sformatf("cas%0d_units", k), un_if.count, k % 10);
            chk($sformatf("cas%0d_tens", k), te_if.count, (k / 10) % 6);
            chk($sformatf("cas%0d_tcarry", k), te_if.carry, k == 59);
            tick();
        end
        un_if.inc = 0;

        // Random stimulus against the model, both u6 and s10
        mm[0] = 6;  mw[0] = 1;
        mm[1] = 10; mw[1] = 0;
        for (int i = 0; i < 500; i++) begin
            bit r, cl[2], ld[2], in[2], de[2], cy, bw;
            int lv[2], pc;
            bit po;
            r = (i == 0) || ($urandom % 60 == 0);
            for (int d = 0; d < 2; d++) begin
                cl[d] = ($urandom % 25) == 0;
                ld[d] = ($urandom % 8) == 0;
                lv[d] = int'($urandom % 16);
                in[d] = $urandom % 2;
                de[d] = ($urandom % 3) == 0;
            end
            reset           = r;
            u6_if.clear     = cl[0]; u6_if.load = ld[0];
            u6_if.load_val  = 4'(lv[0]);
            u6_if.inc       = in[0]; u6_if.dec = de[0];
            s10_if.clear    = cl[1]; s10_if.load = ld[1];
            s10_if.load_val = 4'(lv[1]);
            s10_if.inc      = in[1]; s10_if.dec = de[1];
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                pc = mc[d];
                po = mo[d];
                model(mm[d], mw[d], r, cl[d], ld[d], lv[d], in[d], de[d],
                      mc[d], mo[d], cy, bw);
                if (i > 0) begin
                    chk($sformatf("rnd%0d_d%0d_count", i, d),
                        d == 0 ? u6_if.count : s10_if.count, pc);
                    chk($sformatf("rnd%0d_d%0d_ovf", i, d),
                        d == 0 ? u6_if.overflow : s10_if.overflow, po);
                    chk($sformatf("rnd%0d_d%0d_at_max", i, d),
                        d == 0 ? u6_if.at_max : s10_if.at_max, pc == mm[d] - 1);
                    chk($sformatf("rnd%0d_d%0d_at_zero", i, d),
                        d == 0 ? u6_if.at_zero : s10_if.at_zero, pc == 0);
                end
                chk($sformatf("rnd%0d_d%0d_carry", i, d),
                    d == 0 ? u6_if.carry : s10_if.carry, cy);
                chk($sformatf("rnd%0d_d%0d_borrow", i, d),
                    d == 0 ? u6_if.borrow : s10_if.borrow, bw);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/modn_updown_counter.md
# modn_updown_counter

Parametrised modulo-N digit counter for the stopwatch datapath, generalising the fixed mod-6 digit. Supports a configurable modulus and width, up/down counting, synchronous load and clear, wrap or saturate mode, and a sticky overflow flag. Combinational carry and borrow outputs let digits cascade as seconds-units → seconds-tens → minutes without extra glue. One instance per display digit.

## Interface
- MODULUS, 6, count range 0..MODULUS-1; legal 2..16
- WIDTH, 4, count width; MODULUS ≤ 2**WIDTH
- WRAP, 1, 1 = wrap at the ends; 0 = saturate at the ends
- clock  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high; count ← 0 and overflow ← 0
- clear  in  1  synchronous clear, same effect as reset; driven by the stopwatch controller
- load  in  1  synchronous load of load_val
- load_val  in  WIDTH  value to load
- inc  in  1  count-up request for this cycle; lower digit's carry when cascaded
- dec  in  1  count-down request for this cycle; lower digit's borrow when cascaded
- count  out  WIDTH  registered current value
- carry  out  1  combinational; inc ∧ ¬dec ∧ count==MODULUS-1 ∧ WRAP ∧ ¬(reset∨clear∨load)
- borrow  out  1  combinational; dec ∧ ¬inc ∧ count==0 ∧ WRAP ∧ ¬(reset∨clear∨load)
- at_max  out  1  combinational; count==MODULUS-1
- at_zero  out  1  combinational; count==0
- overflow  out  1  registered, sticky; end-of-range event seen since last reset/clear

## Operation
- Per-cycle operation priority: reset > clear > load > (inc xor dec) > hold.
- load: count ← load_val if load_val < MODULUS, else count ← MODULUS-1 (clamped). No carry or borrow. overflow unchanged.
- inc only:
  - count < MODULUS-1: count+1.
  - At MODULUS-1 with WRAP=1: count ← 0, carry high this cycle.
  - At MODULUS-1 with WRAP=0: count holds, carry stays low.
- dec only:
  - count > 0: count-1.
  - At 0 with WRAP=1: count ← MODULUS-1, borrow high this cycle.
  - At 0 with WRAP=0: count holds, borrow stays low.
- inc ∧ dec together: hold. No carry or borrow. No overflow update.
- overflow ← 1 on any inc-only at MODULUS-1 or dec-only at 0, in either mode. Cleared only by reset or clear.
- Out-of-range count values are unreachable by construction; there is no recovery logic.
- Arithmetic is in WIDTH bits. The next-value compare is against MODULUS-1 (not 2**WIDTH-1), so no intermediate is wider than WIDTH+1.

## Timing
- Reset values: count=0, overflow=0, at_zero=1, at_max=0 (MODULUS≥2), carry=0, borrow=0.
- Latency from any input to count: 1 cycle (value visible after the next rising edge).
- carry, borrow, at_max, at_zero: zero latency, derived from the current count and inputs. The downstream digit samples carry on the same edge that wraps this digit.
- Cascaded chain: the carry path is combinational through every digit. The critical path is N·(compare + AND). This is acceptable for ≤6 digits at the stopwatch clock.
- reset or clear asserted in the same cycle as a wrap: reset/clear wins, count ← 0, carry suppressed.
- load in the same cycle as inc at MODULUS-1: load wins, carry suppressed.

## Structure
- Shared package stopwatch_pkg holds:
  - op encoding OP_HOLD, OP_INC, OP_DEC, OP_LOAD, OP_CLEAR (used by the priority decode);
  - default constants SEC_UNITS_MOD=10, SEC_TENS_MOD=6, MIN_UNITS_MOD=10.
- One sub-module, modn_reg: WIDTH-bit register bank with synchronous active-high reset and a data input. It holds count. overflow is a single flop in the top level.
- Next-value, clamp and terminal-count logic live in the top level.

## Test plan
- MODULUS=6, WRAP=1. reset, then inc held 13 cycles → count 0,1,…,5,0,…,5,0. carry high exactly in the cycles where count==5; overflow=1 after the first wrap.
- MODULUS=6, WRAP=1. From count=0, dec one cycle → count=5, borrow high that cycle. Then dec 5 more → 4,3,2,1,0, borrow low throughout.
- MODULUS=10, WRAP=0. load 9, inc 3 cycles → count stays 9, carry never high, overflow=1. clear → count=0, overflow=0.
- MODULUS=6. load_val=7 with load → count=5. load_val=3 together with inc at count=5 → count=3, carry low.
- Count at 5 (MODULUS=6). inc ∧ dec → count 5, carry low. reset ∧ inc → count 0, carry low, overflow 0.
- Two-digit cascade (units MODULUS=10, tens MODULUS=6), units.carry → tens.inc. inc held 60 cycles from reset → tens:units = 5:9 at cycle 59, 0:0 at cycle 60. tens.carry high only in cycle 59.
